// File: rtl/exn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exn_pkg
// Brief    : Shared types for the nested exception unit: cause codes, sysreg
//            map, saved-frame layout and the pipeline stage bundles it reads.
// Revision : 1.0
// ============================================================================
package exn_pkg;

    typedef enum logic [5:0] {
        RST    = 6'd0,
        IRQ    = 6'd1,
        SCALL  = 6'd2,
        UDF    = 6'd3,
        DFAULT = 6'd4
    } exn_e;

    typedef enum logic [31:0] {
        SR_IE    = 32'h0000_1000,
        SR_SIE   = 32'h0000_1001,
        SR_SCR   = 32'h0000_1002,
        SR_ELR   = 32'h0000_1003,
        SR_EINFO = 32'h0000_1004,
        SR_IMASK = 32'h0000_1005,
        SR_IPEND = 32'h0000_1006,
        SR_DEPTH = 32'h0000_1007
    } sreg_e;

    localparam logic [31:0] c_sr_first = 32'h0000_1000;
    localparam logic [31:0] c_sr_last  = 32'h0000_1007;

    typedef struct packed {
        logic        ie;
        logic [1:0]  cr;
        logic [31:0] pc;
        logic [31:0] info;
    } exn_frame_t;

    typedef struct packed {
        logic bubble;
    } ex_out_t;

    typedef struct packed {
        logic        scall;
        logic        udf;
        logic        eret;
        logic        mtsr;
        logic [31:0] alu_res;
        logic [31:0] op3;
        logic        w_cr;
        logic [1:0]  cmp_res;
        logic [31:0] nextpc;
    } mem_out_t;

    function automatic logic sr_mapped(input logic [31:0] addr);
        return (addr >= c_sr_first) && (addr <= c_sr_last);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Brief    : Edge-latched, maskable interrupt pending register with W1C clear
//            and a lowest-index-wins priority encoder.
// Revision : 1.0
// ============================================================================
module irq_arbiter #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               w1c_we,
    input  logic [NUM_IRQ-1:0] w1c_data,
    input  logic               take,
    output logic               valid,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] w_active;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_clr;
    logic [IDX_W-1:0]   w_idx;

    assign w_active = r_pending & r_mask;
    assign w_rise   = irq_in & ~r_prev;

    // Scan downward so the lowest active index is the last one assigned.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = (take && (w_idx == IDX_W'(i))) || (w1c_we && w1c_data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_prev    <= irq_in;
            // A new edge wins over a clear landing in the same cycle.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    assign valid   = |w_active;
    assign idx     = w_idx;
    assign mask    = r_mask;
    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/exn_unit_nested.sv
`default_nettype none
// ============================================================================
// Module   : exn_unit_nested
// Brief    : Exception/interrupt unit with a hardware stack of saved frames so
//            handlers can nest. Option macro: EXN_STACK_OVF_TRAP_EN.
// Revision : 1.0
// ============================================================================
module exn_unit_nested
    import exn_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int STACK_DEPTH = 4,
    parameter int IRQ_BASE    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  ex_out_t            EX,
    input  mem_out_t           MEM,
    input  logic [1:0]         cmp_reg,
    output logic               exn,
    output logic [5:0]         exn_type,
    output logic               eret,
    output logic [31:0]        sr_rdata,
    output logic               sr_hit,
    output logic [31:0]        elr,
    output logic [1:0]         scr
);

    localparam int c_idx_w = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int c_sp_w  = $clog2(STACK_DEPTH + 1);
    localparam int c_fi_w  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

`ifdef EXN_STACK_OVF_TRAP_EN
    localparam bit c_ovf_trap = 1'b1;
`else
    localparam bit c_ovf_trap = 1'b0;
`endif

    logic               r_ie;
    logic [c_sp_w-1:0]  r_sp;
    logic               r_ovf;
    exn_frame_t         r_frames [STACK_DEPTH];

    logic               w_irq_valid;
    logic [c_idx_w-1:0] w_irq_idx;
    logic [NUM_IRQ-1:0] w_mask;
    logic [NUM_IRQ-1:0] w_pending;

    logic               w_sync;
    logic               w_true_ie;
    logic               w_irq_take;
    logic               w_push;
    logic               w_eret;
    logic               w_full;
    logic               w_sr_we;
    logic [5:0]         w_cause;
    logic [c_fi_w-1:0]  w_top_idx;
    logic [c_fi_w-1:0]  w_push_idx;
    exn_frame_t         w_top;
    exn_frame_t         w_new_frame;

    assign w_sync     = MEM.scall | MEM.udf;
    assign w_true_ie  = (MEM.mtsr && (MEM.alu_res == SR_IE)) ? MEM.op3[0] : r_ie;
    assign w_eret     = !rst && !w_sync && MEM.eret;
    assign w_irq_take = !rst && !w_sync && !MEM.eret && w_irq_valid && w_true_ie && !EX.bubble;
    assign w_push     = !rst && (w_sync || w_irq_take);
    assign w_full     = (r_sp == c_sp_w'(STACK_DEPTH));

    assign w_top_idx  = (r_sp == '0) ? '0 : c_fi_w'(r_sp - 1'b1);
    assign w_push_idx = w_full ? c_fi_w'(STACK_DEPTH - 1) : c_fi_w'(r_sp);
    assign w_top      = r_frames[w_top_idx];

    assign w_cause = MEM.scall ? 6'(SCALL) :
                     MEM.udf   ? 6'(UDF)   :
                                 6'(IRQ_BASE) + 6'(w_irq_idx);

    irq_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (c_idx_w)
    ) u_irq_arbiter (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (w_sr_we && (MEM.alu_res == SR_IMASK)),
        .mask_wdata (MEM.op3[NUM_IRQ-1:0]),
        .w1c_we     (w_sr_we && (MEM.alu_res == SR_IPEND)),
        .w1c_data   (MEM.op3[NUM_IRQ-1:0]),
        .take       (w_irq_take),
        .valid      (w_irq_valid),
        .idx        (w_irq_idx),
        .mask       (w_mask),
        .pending    (w_pending)
    );

    // An interrupt may be taken on the strength of an in-flight IE write, so
    // its frame saves that effective value rather than the stale register.
    always_comb begin
        w_new_frame.ie   = w_sync ? r_ie : w_true_ie;
        w_new_frame.cr   = MEM.w_cr ? MEM.cmp_res : cmp_reg;
        w_new_frame.pc   = MEM.nextpc;
        w_new_frame.info = w_sync ? MEM.alu_res : 32'h0;
        if (c_ovf_trap && w_full) begin
            w_new_frame.info = 32'(w_cause);
        end
    end

    always_comb begin
        exn_type = 6'(RST);
        if (!rst) begin
            if (!w_push) begin
                exn_type = '0;
            end else if (c_ovf_trap && w_full) begin
                exn_type = 6'(DFAULT);
            end else begin
                exn_type = w_cause;
            end
        end
    end

    assign exn     = rst | w_push;
    assign eret    = w_eret;
    assign sr_hit  = sr_mapped(MEM.alu_res);
    assign w_sr_we = MEM.mtsr && sr_hit && !exn && !eret;
    assign elr     = w_top.pc;
    assign scr     = w_top.cr;

    always_comb begin
        sr_rdata = '0;
        case (MEM.alu_res)
            SR_IE:    sr_rdata = {31'h0, r_ie};
            SR_SIE:   sr_rdata = {31'h0, w_top.ie};
            SR_SCR:   sr_rdata = {30'h0, w_top.cr};
            SR_ELR:   sr_rdata = w_top.pc;
            SR_EINFO: sr_rdata = w_top.info;
            SR_IMASK: sr_rdata = 32'(w_mask);
            SR_IPEND: sr_rdata = 32'(w_pending);
            SR_DEPTH: sr_rdata = {r_ovf, 31'(r_sp)};
            default:  sr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STACK_DEPTH; k++) begin
                r_frames[k] <= '0;
            end
        end else if (w_push) begin
            r_frames[w_push_idx] <= w_new_frame;
            r_ie                 <= 1'b0;
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_sp <= r_sp + 1'b1;
            end
        end else if (w_eret) begin
            r_ie <= w_top.ie;
            if (r_sp != '0) begin
                r_sp <= r_sp - 1'b1;
            end
        end else if (w_sr_we) begin
            case (MEM.alu_res)
                SR_IE:    r_ie                     <= MEM.op3[0];
                SR_SIE:   r_frames[w_top_idx].ie   <= MEM.op3[0];
                SR_SCR:   r_frames[w_top_idx].cr   <= MEM.op3[1:0];
                SR_ELR:   r_frames[w_top_idx].pc   <= MEM.op3;
                SR_EINFO: r_frames[w_top_idx].info <= MEM.op3;
                SR_DEPTH: r_ovf                    <= 1'b0;
                default:  ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exn_unit_nested.sv
`default_nettype none
// ============================================================================
// Module   : tb_exn_unit_nested
// Brief    : Self-checking bench: decode vector table plus directed sequences
//            for interrupt arbitration, nesting, overflow and write precedence.
// Revision : 1.0
// ============================================================================
module tb_exn_unit_nested;
    import exn_pkg::*;

`ifdef EXN_STACK_OVF_TRAP_EN
    localparam logic [31:0] c_ovf_type = 32'd4;
    localparam logic [31:0] c_ovf_info = 32'd3;
`else
    localparam logic [31:0] c_ovf_type = 32'd3;
    localparam logic [31:0] c_ovf_info = 32'h77;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    ex_out_t     ex;
    mem_out_t    mem;
    logic [1:0]  cmp_reg;
    logic        exn;
    logic [5:0]  exn_type;
    logic        eret;
    logic [31:0] sr_rdata;
    logic        sr_hit;
    logic [31:0] elr;
    logic [1:0]  scr;

    int checks = 0;
    int errors = 0;

    exn_unit_nested #(
        .NUM_IRQ     (8),
        .STACK_DEPTH (2),
        .IRQ_BASE    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .EX       (ex),
        .MEM      (mem),
        .cmp_reg  (cmp_reg),
        .exn      (exn),
        .exn_type (exn_type),
        .eret     (eret),
        .sr_rdata (sr_rdata),
        .sr_hit   (sr_hit),
        .elr      (elr),
        .scr      (scr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        scall;
        logic        udf;
        logic        eret;
        logic [31:0] addr;
        logic        exn;
        logic        eret_o;
        logic        chk_type;
        logic [5:0]  typ;
        logic        hit;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc_idle();
        @(negedge clk);
        mem = '0;
        ex  = '0;
    endtask

    task automatic sr_write(input logic [31:0] a, input logic [31:0] d);
        cyc_idle();
        mem.mtsr    = 1'b1;
        mem.alu_res = a;
        mem.op3     = d;
    endtask

    task automatic sr_check(input string name, input logic [31:0] a, input logic [31:0] e);
        cyc_idle();
        mem.alu_res = a;
        #1;
        chk(name, sr_rdata, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        mem     = '0;
        ex      = '0;
        irq_in  = '0;
        cmp_reg = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rst   scall udf   eret  addr           exn   eret  chkT  type   hit   rdata
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 6'd2, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 6'd2, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1007, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1008, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_1000, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0};

        rst     = 1'b1;
        irq_in  = '0;
        ex      = '0;
        mem     = '0;
        cmp_reg = 2'b00;

        // Decode table, each vector applied from a freshly reset state
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = 1'b1;
            mem = '0;
            ex  = '0;
            @(negedge clk);
            rst         = vecs[i].rst;
            mem.scall   = vecs[i].scall;
            mem.udf     = vecs[i].udf;
            mem.eret    = vecs[i].eret;
            mem.alu_res = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d exn", i), 32'(exn), 32'(vecs[i].exn));
            chk($sformatf("vec%0d eret", i), 32'(eret), 32'(vecs[i].eret_o));
            if (vecs[i].chk_type) begin
                chk($sformatf("vec%0d exn_type", i), 32'(exn_type), 32'(vecs[i].typ));
            end
            chk($sformatf("vec%0d sr_hit", i), 32'(sr_hit), 32'(vecs[i].hit));
            chk($sformatf("vec%0d sr_rdata", i), sr_rdata, vecs[i].rdata);
        end

        // A: single masked interrupt
        do_reset();
        sr_check("A reset DEPTH", SR_DEPTH, 32'h0);
        sr_check("A reset IMASK", SR_IMASK, 32'h0);
        sr_write(SR_IMASK, 32'h05);
        sr_write(SR_IE, 32'h1);
        cyc_idle();
        irq_in = 8'h04;
        cyc_idle();
        mem.nextpc = 32'h100;
        #1;
        chk("A exn", 32'(exn), 32'h1);
        chk("A exn_type", 32'(exn_type), 32'd10);
        cyc_idle();
        #1;
        chk("A exn after take", 32'(exn), 32'h0);
        chk("A elr", elr, 32'h100);
        sr_check("A IPEND", SR_IPEND, 32'h0);
        sr_check("A DEPTH", SR_DEPTH, 32'h1);
        sr_check("A IE", SR_IE, 32'h0);

        // B: simultaneous lines, lowest index first
        do_reset();
        sr_write(SR_IMASK, 32'hFF);
        sr_write(SR_IE, 32'h1);
        cyc_idle();
        irq_in = 8'h0A;
        cyc_idle();
        mem.nextpc = 32'h200;
        #1;
        chk("B first exn", 32'(exn), 32'h1);
        chk("B first type", 32'(exn_type), 32'd9);
        cyc_idle();
        #1;
        chk("B masked by ie", 32'(exn), 32'h0);
        sr_check("B IPEND", SR_IPEND, 32'h08);
        cyc_idle();
        mem.eret = 1'b1;
        #1;
        chk("B eret", 32'(eret), 32'h1);
        chk("B eret no exn", 32'(exn), 32'h0);
        cyc_idle();
        mem.nextpc = 32'h300;
        #1;
        chk("B second exn", 32'(exn), 32'h1);
        chk("B second type", 32'(exn_type), 32'd11);

        // C: nested scall + irq, then unwind
        do_reset();
        cmp_reg = 2'b01;
        sr_write(SR_IMASK, 32'hFF);
        cyc_idle();
        mem.scall   = 1'b1;
        mem.alu_res = 32'h42;
        mem.nextpc  = 32'h400;
        mem.w_cr    = 1'b1;
        mem.cmp_res = 2'b10;
        #1;
        chk("C scall exn", 32'(exn), 32'h1);
        chk("C scall type", 32'(exn_type), 32'd2);
        sr_check("C DEPTH 1", SR_DEPTH, 32'h1);
        sr_check("C EINFO 1", SR_EINFO, 32'h42);
        chk("C scr 1", 32'(scr), 32'h2);
        sr_write(SR_IE, 32'h1);
        cyc_idle();
        irq_in = 8'h01;
        cyc_idle();
        mem.nextpc = 32'h500;
        #1;
        chk("C irq exn", 32'(exn), 32'h1);
        chk("C irq type", 32'(exn_type), 32'd8);
        sr_check("C DEPTH 2", SR_DEPTH, 32'h2);
        sr_check("C EINFO 2", SR_EINFO, 32'h0);
        chk("C elr 2", elr, 32'h500);
        chk("C scr 2", 32'(scr), 32'h1);
        cyc_idle();
        mem.eret = 1'b1;
        #1;
        chk("C eret 1", 32'(eret), 32'h1);
        sr_check("C DEPTH back 1", SR_DEPTH, 32'h1);
        sr_check("C EINFO back", SR_EINFO, 32'h42);
        sr_check("C IE restored", SR_IE, 32'h1);
        chk("C elr back", elr, 32'h400);
        cyc_idle();
        mem.eret = 1'b1;
        sr_check("C DEPTH 0", SR_DEPTH, 32'h0);
        sr_check("C IE after 2nd eret", SR_IE, 32'h0);
        sr_write(SR_SIE, 32'h1);
        cyc_idle();
        mem.eret = 1'b1;
        sr_check("C eret at sp0 DEPTH", SR_DEPTH, 32'h0);
        sr_check("C eret at sp0 IE", SR_IE, 32'h1);

        // D: stack overflow
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc_idle();
            mem.udf     = 1'b1;
            mem.alu_res = 32'h77;
            mem.nextpc  = 32'h600 + 32'(k * 4);
            #1;
            chk($sformatf("D udf%0d type", k), 32'(exn_type), (k < 2) ? 32'd3 : c_ovf_type);
        end
        sr_check("D DEPTH ovf", SR_DEPTH, 32'h8000_0002);
        sr_check("D EINFO", SR_EINFO, c_ovf_info);
        chk("D elr", elr, 32'h608);
        sr_write(SR_DEPTH, 32'h0);
        sr_check("D DEPTH cleared", SR_DEPTH, 32'h2);

        // E: bubble blocks irq; scall outranks irq
        do_reset();
        sr_write(SR_IMASK, 32'hFF);
        sr_write(SR_IE, 32'h1);
        cyc_idle();
        irq_in = 8'h10;
        cyc_idle();
        ex.bubble = 1'b1;
        #1;
        chk("E bubble no exn", 32'(exn), 32'h0);
        cyc_idle();
        mem.scall   = 1'b1;
        mem.alu_res = 32'h5;
        #1;
        chk("E scall exn", 32'(exn), 32'h1);
        chk("E scall type", 32'(exn_type), 32'd2);
        sr_check("E IPEND kept", SR_IPEND, 32'h10);
        sr_check("E DEPTH", SR_DEPTH, 32'h1);

        // F: write precedence, W1C and same-cycle set/clear
        do_reset();
        sr_write(SR_IMASK, 32'h01);
        sr_write(SR_IE, 32'h1);
        cyc_idle();
        irq_in = 8'h01;
        cyc_idle();
        mem.mtsr    = 1'b1;
        mem.alu_res = SR_IE;
        mem.op3     = 32'h0;
        #1;
        chk("F mtsr ie=0 blocks irq", 32'(exn), 32'h0);
        sr_check("F IE", SR_IE, 32'h0);
        sr_check("F IPEND", SR_IPEND, 32'h01);
        cyc_idle();
        mem.udf     = 1'b1;
        mem.mtsr    = 1'b1;
        mem.alu_res = SR_IMASK;
        mem.op3     = 32'hAA;
        #1;
        chk("F udf exn", 32'(exn), 32'h1);
        chk("F udf type", 32'(exn_type), 32'd3);
        sr_check("F IMASK unchanged", SR_IMASK, 32'h01);
        sr_write(SR_IPEND, 32'h03);
        irq_in = 8'h03;
        #1;
        chk("F w1c cycle exn", 32'(exn), 32'h0);
        sr_check("F IPEND set wins", SR_IPEND, 32'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
